// File: rtl/id_stage.sv
// ARM decode stage: 16x32 register file, decode, condition check, RAW hazard.
// Optional macro REG_BYPASS_EN: same-cycle WB write-through on reads.
module id_stage #(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instruction,
  input  logic [3:0]        status,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic              mem_wb_en,
  input  logic [3:0]        mem_dest,
  output logic [31:0]       pc,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              wb_en,
  output logic              status_w_en,
  output logic              branch_taken,
  output logic              imm,
  output logic [3:0]        exec_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic [23:0]       signed_immed_24,
  output logic [3:0]        dest,
  output logic [11:0]       shift_operand,
  output logic [3:0]        src_1,
  output logic [3:0]        src_2,
  output logic              hazard
);

  logic [DATA_W-1:0] regfile_q [REG_COUNT];

  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_ok;
  logic       mem_r_raw, mem_w_raw, wb_raw, s_raw, br_raw;
  logic       uses_rn, two_src;
  logic       hit_rn, hit_rm;
  logic       bubble;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign {n_f, z_f, c_f, v_f} = status;

  assign pc              = pc_in;
  assign imm             = instruction[25];
  assign signed_immed_24 = instruction[23:0];
  assign dest            = instruction[15:12];
  assign shift_operand   = instruction[11:0];
  assign src_1           = instruction[19:16];
  assign src_2 = mem_w_raw ? instruction[15:12]
                           : instruction[3:0];

  // Register file: async clear, write from WB on rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++)
        regfile_q[i] <= '0;
    end else if (wb_wb_en) begin
      regfile_q[wb_dest] <= wb_value;
    end
  end

`ifdef REG_BYPASS_EN
  assign val_rn = (wb_wb_en && wb_dest == src_1)
                ? wb_value : regfile_q[src_1];
  assign val_rm = (wb_wb_en && wb_dest == src_2)
                ? wb_value : regfile_q[src_2];
`else
  assign val_rn = regfile_q[src_1];
  assign val_rm = regfile_q[src_2];
`endif

  // Instruction decode into raw (pre-bubble) control
  always_comb begin
    exec_cmd  = 4'b0000;
    mem_r_raw = 1'b0;
    mem_w_raw = 1'b0;
    wb_raw    = 1'b0;
    s_raw     = 1'b0;
    br_raw    = 1'b0;
    unique case (mode)
      2'b00: begin
        s_raw  = s_bit;
        wb_raw = 1'b1;
        unique case (opcode)
          4'b1101: exec_cmd = 4'b0001;
          4'b1111: exec_cmd = 4'b1001;
          4'b0100: exec_cmd = 4'b0010;
          4'b0101: exec_cmd = 4'b0011;
          4'b0010: exec_cmd = 4'b0100;
          4'b0110: exec_cmd = 4'b0101;
          4'b0000: exec_cmd = 4'b0110;
          4'b1100: exec_cmd = 4'b0111;
          4'b0001: exec_cmd = 4'b1000;
          4'b1010: begin
            exec_cmd = 4'b0100;
            wb_raw   = 1'b0;
          end
          4'b1000: begin
            exec_cmd = 4'b0110;
            wb_raw   = 1'b0;
          end
          default: begin
            wb_raw = 1'b0;
            s_raw  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        exec_cmd  = 4'b0010;
        mem_r_raw = s_bit;
        wb_raw    = s_bit;
        mem_w_raw = !s_bit;
      end
      2'b10: br_raw = 1'b1;
      default: ;
    endcase
  end

  // Condition field evaluated against NZCV
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = 1'b0;
    endcase
  end

  assign uses_rn = (mode != 2'b10) &&
    !(mode == 2'b00 &&
      (opcode == 4'b1101 || opcode == 4'b1111));
  assign two_src = !imm || mem_w_raw;

  // RAW match of both sources against in-flight writers
  always_comb begin
    hit_rn = (exe_wb_en && exe_dest == src_1) ||
             (mem_wb_en && mem_dest == src_1);
    hit_rm = (exe_wb_en && exe_dest == src_2) ||
             (mem_wb_en && mem_dest == src_2);
`ifndef REG_BYPASS_EN
    hit_rn = hit_rn || (wb_wb_en && wb_dest == src_1);
    hit_rm = hit_rm || (wb_wb_en && wb_dest == src_2);
`endif
  end

  assign hazard = (uses_rn && hit_rn) ||
                  (two_src && hit_rm);
  assign bubble = !cond_ok || hazard;

  assign mem_r_en     = mem_r_raw && !bubble;
  assign mem_w_en     = mem_w_raw && !bubble;
  assign wb_en        = wb_raw    && !bubble;
  assign status_w_en  = s_raw     && !bubble;
  assign branch_taken = br_raw    && !bubble;

endmodule
